// File: rtl/driver_cmd_decoder.sv
// ----------------------------------------------------------------------------
// driver_cmd_decoder
//
// Receive-side decoder for one lane of the LED-driver serial command
// interface (SCLK / LAT / SIN). SIN is shifted in MSB first on every SCLK
// rising edge (sclk_en=1). The length of each LAT-high pulse, counted in SCLK
// edges, selects the command. The command is decoded on the first LAT-low
// edge after the pulse. The data word used is the 48 bits that ended with
// the last LAT-high bit.
//
// Ports
//   clk_33          in   system clock
//   nrst            in   asynchronous active-low reset
//   sclk_en         in   qualifies a cycle as an SCLK rising edge
//   lat             in   LAT line, sampled only when sclk_en=1
//   sin             in   serial data, sampled only when sclk_en=1
//   err_clr         in   clears the sticky error flags
//   cmd_valid       out  one-cycle pulse per decoded command
//   cmd_code        out  decoded command code (7 = INVALID)
//   gs_word         out  last captured GS word
//   gs_word_idx     out  bank slot of gs_word
//   gs_word_valid   out  pulse, gs_word / gs_word_idx valid
//   gs_bank_latched out  pulse on LATGS or LINERESET
//   conf_reg        out  last accepted configuration word
//   conf_valid      out  pulse when conf_reg updates
//   err_fc_locked   out  sticky, WRTFC without a preceding FCWRTEN
//   err_bad_lat     out  sticky, unknown LAT length
//   err_gs_overflow out  sticky, too many WRTGS before a LATGS
// ----------------------------------------------------------------------------
module driver_cmd_decoder #(
    parameter int DATA_W   = 48,
    parameter int GS_WORDS = 9,
    parameter int LATCNT_W = 5
) (
    input  logic              clk_33,
    input  logic              nrst,
    input  logic              sclk_en,
    input  logic              lat,
    input  logic              sin,
    input  logic              err_clr,
    output logic              cmd_valid,
    output logic [2:0]        cmd_code,
    output logic [DATA_W-1:0] gs_word,
    output logic [3:0]        gs_word_idx,
    output logic              gs_word_valid,
    output logic              gs_bank_latched,
    output logic [DATA_W-1:0] conf_reg,
    output logic              conf_valid,
    output logic              err_fc_locked,
    output logic              err_bad_lat,
    output logic              err_gs_overflow
);

    typedef enum logic [2:0] {
        CMD_WRTGS     = 3'd0,
        CMD_LATGS     = 3'd1,
        CMD_WRTFC     = 3'd2,
        CMD_LINERESET = 3'd3,
        CMD_READFC    = 3'd4,
        CMD_TMGRST    = 3'd5,
        CMD_FCWRTEN   = 3'd6,
        CMD_INVALID   = 3'd7
    } cmd_e;

    // LAT pulse lengths in SCLK edges
    localparam logic [LATCNT_W-1:0] LEN_WRTGS     = LATCNT_W'(1);
    localparam logic [LATCNT_W-1:0] LEN_LATGS     = LATCNT_W'(3);
    localparam logic [LATCNT_W-1:0] LEN_WRTFC     = LATCNT_W'(5);
    localparam logic [LATCNT_W-1:0] LEN_LINERESET = LATCNT_W'(7);
    localparam logic [LATCNT_W-1:0] LEN_READFC    = LATCNT_W'(11);
    localparam logic [LATCNT_W-1:0] LEN_TMGRST    = LATCNT_W'(13);
    localparam logic [LATCNT_W-1:0] LEN_FCWRTEN   = LATCNT_W'(15);

    localparam logic [3:0] IDX_LAST = 4'(GS_WORDS - 1);

    logic [DATA_W-1:0]   r_shift;
    logic [LATCNT_W-1:0] r_lat_cnt;
    logic [3:0]          r_idx;
    logic                r_fc_unlocked;

    // A decode happens on the first LAT-low edge that follows a LAT pulse.
    logic w_decode;
    assign w_decode = sclk_en && !lat && (r_lat_cnt != '0);

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_shift         <= '0;
            r_lat_cnt       <= '0;
            r_idx           <= '0;
            r_fc_unlocked   <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_code        <= CMD_WRTGS;
            gs_word         <= '0;
            gs_word_idx     <= '0;
            gs_word_valid   <= 1'b0;
            gs_bank_latched <= 1'b0;
            conf_reg        <= '0;
            conf_valid      <= 1'b0;
            err_fc_locked   <= 1'b0;
            err_bad_lat     <= 1'b0;
            err_gs_overflow <= 1'b0;
        end else begin
            cmd_valid       <= 1'b0;
            gs_word_valid   <= 1'b0;
            gs_bank_latched <= 1'b0;
            conf_valid      <= 1'b0;

            // Clear first so that an error raised in the same cycle, assigned
            // further down, takes precedence.
            if (err_clr) begin
                err_fc_locked   <= 1'b0;
                err_bad_lat     <= 1'b0;
                err_gs_overflow <= 1'b0;
            end

            if (sclk_en) begin
                r_shift <= {r_shift[DATA_W-2:0], sin};

                if (lat) begin
                    if (r_lat_cnt != '1) begin
                        r_lat_cnt <= r_lat_cnt + LATCNT_W'(1);
                    end
                end else if (w_decode) begin
                    // r_shift still holds the word ending with the last
                    // LAT-high bit; this edge's sin is only shifted in.
                    r_lat_cnt <= '0;
                    cmd_valid <= 1'b1;

                    case (r_lat_cnt)
                        LEN_WRTGS: begin
                            cmd_code      <= CMD_WRTGS;
                            gs_word       <= r_shift;
                            gs_word_idx   <= r_idx;
                            gs_word_valid <= 1'b1;
                            if (r_idx < IDX_LAST) begin
                                r_idx <= r_idx + 4'd1;
                            end else begin
                                err_gs_overflow <= 1'b1;
                            end
                        end
                        LEN_LATGS, LEN_LINERESET: begin
                            cmd_code        <= (r_lat_cnt == LEN_LATGS) ? CMD_LATGS
                                                                        : CMD_LINERESET;
                            gs_word         <= r_shift;
                            gs_word_idx     <= IDX_LAST;
                            gs_word_valid   <= 1'b1;
                            gs_bank_latched <= 1'b1;
                            r_idx           <= '0;
                        end
                        LEN_WRTFC: begin
                            cmd_code <= CMD_WRTFC;
                            if (r_fc_unlocked) begin
                                conf_reg      <= r_shift;
                                conf_valid    <= 1'b1;
                                r_fc_unlocked <= 1'b0;
                            end else begin
                                err_fc_locked <= 1'b1;
                            end
                        end
                        LEN_FCWRTEN: begin
                            cmd_code      <= CMD_FCWRTEN;
                            r_fc_unlocked <= 1'b1;
                        end
                        LEN_READFC: begin
                            cmd_code <= CMD_READFC;
                        end
                        LEN_TMGRST: begin
                            cmd_code <= CMD_TMGRST;
                        end
                        default: begin
                            // Includes the saturated count.
                            cmd_code    <= CMD_INVALID;
                            err_bad_lat <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_driver_cmd_decoder.sv
module tb_driver_cmd_decoder;

    localparam int DATA_W = 48;

    logic              clk_33  = 1'b0;
    logic              nrst    = 1'b0;
    logic              sclk_en = 1'b0;
    logic              lat     = 1'b0;
    logic              sin     = 1'b0;
    logic              err_clr = 1'b0;
    logic              cmd_valid;
    logic [2:0]        cmd_code;
    logic [DATA_W-1:0] gs_word;
    logic [3:0]        gs_word_idx;
    logic              gs_word_valid;
    logic              gs_bank_latched;
    logic [DATA_W-1:0] conf_reg;
    logic              conf_valid;
    logic              err_fc_locked;
    logic              err_bad_lat;
    logic              err_gs_overflow;

    driver_cmd_decoder #(
        .DATA_W  (48),
        .GS_WORDS(9),
        .LATCNT_W(5)
    ) dut (
        .clk_33         (clk_33),
        .nrst           (nrst),
        .sclk_en        (sclk_en),
        .lat            (lat),
        .sin            (sin),
        .err_clr        (err_clr),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .gs_word        (gs_word),
        .gs_word_idx    (gs_word_idx),
        .gs_word_valid  (gs_word_valid),
        .gs_bank_latched(gs_bank_latched),
        .conf_reg       (conf_reg),
        .conf_valid     (conf_valid),
        .err_fc_locked  (err_fc_locked),
        .err_bad_lat    (err_bad_lat),
        .err_gs_overflow(err_gs_overflow)
    );

    always #15 clk_33 = ~clk_33;

    int checks   = 0;
    int failures = 0;

    // Log of every pulse seen on the outputs
    logic [2:0]  q_cmd[$];
    logic [3:0]  q_idx[$];
    logic [47:0] q_word[$];
    logic        q_bank_at[$];
    logic        q_ovf[$];
    int          n_bank = 0;
    int          n_conf = 0;
    logic        clr_on_edge = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic record();
        if (cmd_valid) q_cmd.push_back(cmd_code);
        if (gs_word_valid) begin
            q_idx.push_back(gs_word_idx);
            q_word.push_back(gs_word);
            q_bank_at.push_back(gs_bank_latched);
            q_ovf.push_back(err_gs_overflow);
        end
        if (gs_bank_latched) n_bank++;
        if (conf_valid) n_conf++;
    endtask

    task automatic clear_log();
        q_cmd.delete();
        q_idx.delete();
        q_word.delete();
        q_bank_at.delete();
        q_ovf.delete();
        n_bank = 0;
        n_conf = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_33);
            record();
        end
    endtask

    // One SCLK edge: sclk_en high for one cycle, results sampled at the
    // following falling edge, then one idle cycle lets the pulses drop.
    task automatic sclk_edge(input logic s, input logic l);
        @(negedge clk_33);
        sclk_en = 1'b1;
        sin     = s;
        lat     = l;
        err_clr = clr_on_edge;
        @(negedge clk_33);
        sclk_en = 1'b0;
        err_clr = 1'b0;
        record();
    endtask

    // Blanking: lat and sin toggle but sclk_en stays low.
    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_33);
            sclk_en = 1'b0;
            lat     = i[0];
            sin     = i[1];
            record();
        end
        lat = 1'b0;
        sin = 1'b0;
    endtask

    // 48 bits MSB first, lat high on the last nlat bits; blanking inserted
    // before bit blank_at when it is in range.
    task automatic send_word(input logic [47:0] w, input int nlat, input int blank_at);
        for (int b = 47; b >= 0; b--) begin
            if (b == blank_at) blank(40);
            sclk_edge(w[b], (b < nlat));
        end
    endtask

    task automatic lat_pulse(input int n);
        repeat (n) sclk_edge(1'b0, 1'b1);
        sclk_edge(1'b0, 1'b0);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk_33);
        err_clr = 1'b1;
        @(negedge clk_33);
        err_clr = 1'b0;
        record();
    endtask

    initial begin
        // ---------------- reset state ----------------
        nrst = 1'b0;
        idle(3);
        check("reset_ctrl", {cmd_valid, cmd_code, gs_word_idx, gs_word_valid, gs_bank_latched,
                             conf_valid, err_fc_locked, err_bad_lat, err_gs_overflow}, 64'h0);
        check("reset_gs_word", gs_word, 64'h0);
        check("reset_conf_reg", conf_reg, 64'h0);
        @(negedge clk_33);
        nrst = 1'b1;
        idle(2);
        clear_log();

        // ---------------- config boot ----------------
        repeat (15) sclk_edge(1'b0, 1'b1);
        send_word(48'hA5A5_0F0F_1234, 5, -1);
        sclk_edge(1'b0, 1'b0);
        idle(2);
        check("boot_ncmd", q_cmd.size(), 2);
        check("boot_cmd0", q_cmd[0], 6);
        check("boot_cmd1", q_cmd[1], 2);
        check("boot_nconf", n_conf, 1);
        check("boot_conf_reg", conf_reg, 48'hA5A5_0F0F_1234);
        check("boot_errs", {err_fc_locked, err_bad_lat, err_gs_overflow}, 0);
        check("boot_no_gs", q_idx.size(), 0);

        // ---------------- stream frame with blanking ----------------
        clear_log();
        blank(40);
        for (int k = 1; k <= 8; k++) send_word(48'(k), 1, (k == 1) ? 24 : -1);
        send_word(48'hFFFF, 3, -1);
        sclk_edge(1'b0, 1'b0);
        idle(2);
        check("frame_ngs", q_idx.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("frame_idx%0d", k), q_idx[k], k);
            check($sformatf("frame_word%0d", k), q_word[k], (k < 8) ? 48'(k + 1) : 48'hFFFF);
        end
        check("frame_ncmd", q_cmd.size(), 9);
        check("frame_cmd7", q_cmd[7], 0);
        check("frame_cmd8", q_cmd[8], 1);
        check("frame_nbank", n_bank, 1);
        check("frame_bank_on9", q_bank_at[8], 1);
        check("frame_bank_on8", q_bank_at[7], 0);
        check("frame_ovf", err_gs_overflow, 0);

        // ---------------- WRTFC while locked ----------------
        @(negedge clk_33);
        nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
        idle(1);
        clear_log();
        send_word(48'h1234_5678_9ABC, 5, -1);
        sclk_edge(1'b0, 1'b0);
        idle(2);
        check("lock_ncmd", q_cmd.size(), 1);
        check("lock_cmd", q_cmd[0], 2);
        check("lock_nconf", n_conf, 0);
        check("lock_conf_reg", conf_reg, 0);
        check("lock_err", err_fc_locked, 1);
        pulse_err_clr();
        check("lock_err_clr", err_fc_locked, 0);
        // err_clr on the same edge as a fresh error: the error wins
        send_word(48'h0000_0000_0055, 5, -1);
        clr_on_edge = 1'b1;
        sclk_edge(1'b0, 1'b0);
        clr_on_edge = 1'b0;
        idle(1);
        check("lock_err_wins", err_fc_locked, 1);
        check("lock_conf_still0", conf_reg, 0);
        pulse_err_clr();

        // ---------------- bad LAT lengths ----------------
        clear_log();
        lat_pulse(2);
        idle(1);
        check("bad2_cmd", q_cmd[0], 7);
        check("bad2_err", err_bad_lat, 1);
        pulse_err_clr();
        check("bad_err_clr", err_bad_lat, 0);
        lat_pulse(40);
        idle(1);
        check("bad_ncmd", q_cmd.size(), 2);
        check("bad40_cmd", q_cmd[1], 7);
        check("bad40_err", err_bad_lat, 1);
        check("bad_no_gs", q_idx.size(), 0);
        pulse_err_clr();

        // ---------------- GS overflow ----------------
        clear_log();
        for (int k = 0; k < 10; k++) send_word(48'h100 + 48'(k), 1, -1);
        send_word(48'hAAA, 3, -1);
        send_word(48'h200, 1, -1);
        sclk_edge(1'b0, 1'b0);
        idle(2);
        check("ovf_ngs", q_idx.size(), 12);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("ovf_idx%0d", k), q_idx[k], (k < 8) ? k : 8);
            check($sformatf("ovf_flag%0d", k), q_ovf[k], (k < 8) ? 1'b0 : 1'b1);
            check($sformatf("ovf_word%0d", k), q_word[k], 48'h100 + 48'(k));
        end
        check("ovf_latgs_idx", q_idx[10], 8);
        check("ovf_latgs_bank", q_bank_at[10], 1);
        check("ovf_after_idx", q_idx[11], 0);
        check("ovf_after_word", q_word[11], 48'h200);
        pulse_err_clr();

        // ---------------- reset mid-LAT ----------------
        clear_log();
        repeat (10) sclk_edge(1'b0, 1'b1);
        @(negedge clk_33);
        #3 nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
        idle(1);
        send_word(48'hBEEF, 1, -1);
        sclk_edge(1'b0, 1'b0);
        idle(2);
        check("abort_ncmd", q_cmd.size(), 1);
        check("abort_cmd", q_cmd[0], 0);
        check("abort_idx", q_idx[0], 0);
        check("abort_word", q_word[0], 48'hBEEF);
        check("abort_errs", {err_fc_locked, err_bad_lat, err_gs_overflow}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
